// File: rtl/peripheral_msi_pkg.sv
// Shared definitions for the MSI peripheral-fabric Wishbone arbiter:
// grant FSM state encoding and width helpers for the owner index and watchdog.
package peripheral_msi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HANDOVER = 2'd3
    } arb_state_e;

    // Width of an owner index; a single master still needs one bit.
    function automatic int MASTER_SEL_BITS(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    // Width of the watchdog counter, which only has to reach TIMEOUT-1.
    function automatic int WDOG_W(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/peripheral_msi_rr_pick.sv
// Rotating-priority picker: returns the first requester after 'last',
// scanning last+1, last+2, ... modulo NUM_MASTERS.
module peripheral_msi_rr_pick
    import peripheral_msi_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int SW          = MASTER_SEL_BITS(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SW-1:0]          last,
    output logic                   found,
    output logic [SW-1:0]          sel
);

    function automatic int wrap_idx(input int base, input int offset);
        return (base + offset) % NUM_MASTERS;
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        sel   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (req[wrap_idx(int'(last), i)]) begin
                found = 1'b1;
                sel   = SW'(wrap_idx(int'(last), i));
            end
        end
    end

endmodule

// File: rtl/peripheral_msi_rr_arbiter_wb.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port
// through a registered grant FSM with a one-cycle handover bubble.
// Optional per-transaction watchdog enabled by the macro
// PERIPHERAL_MSI_ARBITER_WB_WATCHDOG_EN; without it timeout_o is tied low
// and the owner keeps the slave until it drops cyc.
module peripheral_msi_rr_arbiter_wb
    import peripheral_msi_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [NUM_MASTERS-1:0][AW-1:0]  wbm_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_i,
    input  logic [NUM_MASTERS-1:0][3:0]     wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]          wbm_we_i,
    input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
    input  logic [NUM_MASTERS-1:0][2:0]     wbm_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]     wbm_bte_i,
    output logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_o,
    output logic [NUM_MASTERS-1:0]          wbm_ack_o,
    output logic [NUM_MASTERS-1:0]          wbm_err_o,
    output logic [NUM_MASTERS-1:0]          wbm_rty_o,
    output logic [AW-1:0]                   wbs_adr_o,
    output logic [DW-1:0]                   wbs_dat_o,
    output logic [3:0]                      wbs_sel_o,
    output logic                            wbs_we_o,
    output logic                            wbs_cyc_o,
    output logic                            wbs_stb_o,
    output logic [2:0]                      wbs_cti_o,
    output logic [1:0]                      wbs_bte_o,
    input  logic [DW-1:0]                   wbs_dat_i,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            timeout_o
);

    localparam int SW = MASTER_SEL_BITS(NUM_MASTERS);

    arb_state_e    state_q;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] last_q;
    logic          pick_found;
    logic [SW-1:0] pick_sel;
    logic          in_grant;
    logic          owner_cyc;
    logic          fire;

    peripheral_msi_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .SW          (SW)
    ) u_pick (
        .req   (wbm_cyc_i),
        .last  (last_q),
        .found (pick_found),
        .sel   (pick_sel)
    );

    assign in_grant  = (state_q == ST_GRANT);
    assign owner_cyc = wbm_cyc_i[sel_q];

`ifdef PERIPHERAL_MSI_ARBITER_WB_WATCHDOG_EN
    localparam int WW = WDOG_W(TIMEOUT);

    logic [WW-1:0] wdog_q;
    logic          slave_resp;

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // A response in the firing cycle wins over the timeout.
    assign fire       = in_grant && !slave_resp && (wdog_q == WW'(TIMEOUT - 1));
    assign timeout_o  = fire;

    // Count stalled strobe cycles of the current owner; clear while idle and on any response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdog_q <= '0;
        end else if (state_q == ST_IDLE || slave_resp) begin
            wdog_q <= '0;
        end else if (in_grant && wbs_stb_o) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    assign fire      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Grant FSM: pick in IDLE, serve in GRANT, drain in FLUSH, one bubble in HANDOVER.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: reset is sampled on the clock edge only; state updates use non-blocking assignments.
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SW'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        sel_q   <= pick_sel;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (fire) begin
                        state_q <= ST_FLUSH;
                    end else if (!owner_cyc) begin
                        last_q  <= sel_q;
                        state_q <= ST_HANDOVER;
                    end
                end
                ST_FLUSH: begin
                    if (!owner_cyc) begin
                        last_q  <= sel_q;
                        state_q <= ST_HANDOVER;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Slave request mux and per-master response routing; handshakes only reach the slave in GRANT.
    always_comb begin
        wbs_adr_o = wbm_adr_i[sel_q];
        wbs_dat_o = wbm_dat_i[sel_q];
        wbs_sel_o = wbm_sel_i[sel_q];
        wbs_we_o  = wbm_we_i[sel_q];
        wbs_cti_o = wbm_cti_i[sel_q];
        wbs_bte_o = wbm_bte_i[sel_q];
        wbs_cyc_o = in_grant & wbm_cyc_i[sel_q];
        wbs_stb_o = in_grant & wbm_stb_i[sel_q];
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        grant_o   = '0;
        if (in_grant) begin
            wbm_ack_o[sel_q] = wbs_ack_i;
            wbm_err_o[sel_q] = wbs_err_i | fire;
            wbm_rty_o[sel_q] = wbs_rty_i;
        end
        if (state_q == ST_GRANT || state_q == ST_FLUSH) begin
            grant_o[sel_q] = 1'b1;
        end
    end

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

endmodule
